// File: rtl/clique_dispatch_pkg.sv
// Shared sizing constants for the clique dispatcher.
// Parameter defaults for the top and the bench come from here.
package clique_dispatch_pkg;

    localparam int N_UNITS_DEF        = 4;
    localparam int N_UNITSBITS        = 2;
    localparam int MAX_CLIQUESIZEBITS = 8;
    localparam int VERTEX_BITS        = 16;

endpackage

// File: rtl/pipe_interlock.sv
// One-entry valid/ready register slice.
// It accepts a new word in the same cycle the held word drains.
module pipe_interlock #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             full_q;
    logic [WIDTH-1:0] data_q;

    assign in_ready_o  = !full_q || out_ready_i;
    assign out_valid_o = full_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            full_q <= 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            full_q <= 1'b1;
        end else if (out_ready_i) begin
            full_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (in_valid_i && in_ready_o) begin
            data_q <= in_data_i;
        end
    end

endmodule

// File: rtl/clique_dispatch.sv
// Round-robin dispatcher: streams each clique whole to one ready unit
// through a single output register that fans out per unit.
//
// state    | meaning
// S_SELECT | waiting for input and a ready unit; no beats accepted
// S_STREAM | forwarding beats of the current clique to target_q
module clique_dispatch
    import clique_dispatch_pkg::*;
#(
    parameter int N_UNITS   = N_UNITS_DEF,
    parameter int SIZE_BITS = MAX_CLIQUESIZEBITS
) (
    input  logic                           i_clk300,
    input  logic                           i_reset,
    input  logic                           i_clq_valid,
    input  logic [SIZE_BITS-1:0]           i_clq_size,
    input  logic [15:0]                    i_clq_vertex,
    input  logic                           i_clq_strobe,
    output logic                           o_clq_accept,
    input  logic [N_UNITS-1:0]             i_unit_ready,
    output logic [N_UNITS-1:0]             o_clq_valid,
    output logic [N_UNITS-1:0]             o_clq_strobe,
    output logic [N_UNITS*SIZE_BITS-1:0]   o_clq_size,
    output logic [N_UNITS*16-1:0]          o_clq_vertex,
    input  logic [N_UNITS-1:0]             i_clq_accept,
    output logic [31:0]                    o_clq_count,
    output logic                           o_busy
);

    localparam int UB = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
    localparam int DW = SIZE_BITS + VERTEX_BITS + 1;

    localparam logic [0:0] S_SELECT = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [UB-1:0]        target_q, target_d;
    logic [UB-1:0]        rr_ptr_q, rr_ptr_d;
    logic [31:0]          count_q;

    logic [UB-1:0]        pick_idx;
    logic                 pick_found;

    logic                 pipe_in_ready;
    logic                 out_full;
    logic [DW-1:0]        out_data;
    logic                 out_strobe;
    logic [SIZE_BITS-1:0] out_size;
    logic [15:0]          out_vertex;
    logic                 drain;
    logic                 push;
    logic                 stream_accept;

    assign drain         = out_full && i_clq_accept[target_q];
    assign stream_accept = (state_q == S_STREAM) && pipe_in_ready && !i_reset;
    assign push          = stream_accept && i_clq_valid;
    assign o_clq_accept  = stream_accept;

    assign {out_strobe, out_size, out_vertex} = out_data;

    pipe_interlock #(
        .WIDTH(DW)
    ) u_out_reg (
        .clk_i      (i_clk300),
        .reset_i    (i_reset),
        .in_valid_i (push),
        .in_ready_o (pipe_in_ready),
        .in_data_i  ({i_clq_strobe, i_clq_size, i_clq_vertex}),
        .out_valid_o(out_full),
        .out_ready_i(i_clq_accept[target_q]),
        .out_data_o (out_data)
    );

    // First ready unit at or after rr_ptr_q, wrapping; N_UNITS is a power of two.
    always_comb begin
        pick_idx   = rr_ptr_q;
        pick_found = 1'b0;
        for (int k = 0; k < N_UNITS; k++) begin
            logic [UB-1:0] idx;
            idx = rr_ptr_q + UB'(k);
            if (!pick_found && i_unit_ready[idx]) begin
                pick_found = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            S_SELECT: begin
                // The fan-out follows target_q, so it may only move once the register empties.
                if (i_clq_valid && pick_found && (!out_full || drain)) begin
                    state_d  = S_STREAM;
                    target_d = pick_idx;
                    rr_ptr_d = pick_idx + UB'(1);
                end
            end
            S_STREAM: begin
                if (push && i_clq_strobe) begin
                    state_d = S_SELECT;
                end
            end
            default: state_d = S_SELECT;
        endcase
    end

    always_ff @(posedge i_clk300) begin
        if (i_reset) begin
            state_q  <= S_SELECT;
            target_q <= '0;
            rr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            rr_ptr_q <= rr_ptr_d;
            if (drain && out_strobe && (count_q != 32'hFFFF_FFFF)) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    always_comb begin
        o_clq_valid  = '0;
        o_clq_strobe = '0;
        o_clq_size   = '0;
        o_clq_vertex = '0;
        o_clq_valid[target_q]  = out_full;
        o_clq_strobe[target_q] = out_full && out_strobe;
        o_clq_size[int'(target_q)*SIZE_BITS +: SIZE_BITS] = out_size;
        o_clq_vertex[int'(target_q)*16 +: 16]             = out_vertex;
    end

    assign o_clq_count = count_q;
    assign o_busy      = (state_q != S_SELECT) || out_full;

endmodule

// File: tb/tb_clique_dispatch.sv
// Scoreboard bench for clique_dispatch with four units.
module tb_clique_dispatch;
    import clique_dispatch_pkg::*;

    localparam int N  = 4;
    localparam int SB = MAX_CLIQUESIZEBITS;

    logic              clk = 1'b0;
    logic              i_reset;
    logic              i_clq_valid;
    logic [SB-1:0]     i_clq_size;
    logic [15:0]       i_clq_vertex;
    logic              i_clq_strobe;
    logic              o_clq_accept;
    logic [N-1:0]      i_unit_ready;
    logic [N-1:0]      o_clq_valid;
    logic [N-1:0]      o_clq_strobe;
    logic [N*SB-1:0]   o_clq_size;
    logic [N*16-1:0]   o_clq_vertex;
    logic [N-1:0]      i_clq_accept;
    logic [31:0]       o_clq_count;
    logic              o_busy;

    typedef struct packed {
        logic [4:0]    unit;
        logic          strobe;
        logic [SB-1:0] size;
        logic [15:0]   vertex;
    } beat_t;

    beat_t sb_q[$];
    int    checks_total = 0;
    int    checks_passed = 0;
    int    model_rr = 0;
    int    model_count = 0;
    int    sink_mode = 0;
    bit    mon_en = 1'b0;

    always #5 clk = ~clk;

    clique_dispatch #(
        .N_UNITS  (N),
        .SIZE_BITS(SB)
    ) dut (
        .i_clk300    (clk),
        .i_reset     (i_reset),
        .i_clq_valid (i_clq_valid),
        .i_clq_size  (i_clq_size),
        .i_clq_vertex(i_clq_vertex),
        .i_clq_strobe(i_clq_strobe),
        .o_clq_accept(o_clq_accept),
        .i_unit_ready(i_unit_ready),
        .o_clq_valid (o_clq_valid),
        .o_clq_strobe(o_clq_strobe),
        .o_clq_size  (o_clq_size),
        .o_clq_vertex(o_clq_vertex),
        .i_clq_accept(i_clq_accept),
        .o_clq_count (o_clq_count),
        .o_busy      (o_busy)
    );

    // Sink: mode 0 always accepts, mode 1 toggles every cycle.
    initial begin
        i_clq_accept = '0;
        forever begin
            @(posedge clk);
            #1;
            case (sink_mode)
                0: i_clq_accept = '1;
                1: i_clq_accept = (i_clq_accept == '0) ? '1 : '0;
                default: i_clq_accept = '0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en && !i_reset) begin
            for (int u = 0; u < N; u++) begin
                if (o_clq_valid[u] && i_clq_accept[u]) begin
                    beat_t        got;
                    beat_t        exp;
                    logic [N-1:0] onehot;
                    onehot     = '0;
                    onehot[u]  = 1'b1;
                    got.unit   = 5'(u);
                    got.strobe = o_clq_strobe[u];
                    got.size   = o_clq_size[u*SB +: SB];
                    got.vertex = o_clq_vertex[u*16 +: 16];
                    checks_total++;
                    if (sb_q.size() == 0) begin
                        $display("FAIL scoreboard_unexpected got unit=%0d vertex=%h required no beat",
                                 u, got.vertex);
                    end else begin
                        exp = sb_q.pop_front();
                        if (got !== exp || o_clq_valid !== onehot)
                            $display("FAIL scoreboard_beat got unit=%0d strb=%0b size=%h vtx=%h valid=%b required unit=%0d strb=%0b size=%h vtx=%h",
                                     got.unit, got.strobe, got.size, got.vertex, o_clq_valid,
                                     exp.unit, exp.strobe, exp.size, exp.vertex);
                        else
                            checks_passed++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    function automatic int pick_unit(input logic [N-1:0] rdy);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (model_rr + k) % N;
            if (rdy[idx]) begin
                model_rr = (idx + 1) % N;
                return idx;
            end
        end
        return 0;
    endfunction

    task automatic send_clique(input int unit_exp, input int nbeats, input logic [15:0] vbase,
                               input logic [SB-1:0] sz, input bit with_strobe,
                               output int first_wait, output int span);
        int waited;
        bit timed_out;
        timed_out  = 1'b0;
        first_wait = 0;
        span       = 0;
        for (int b = 0; b < nbeats; b++) begin
            beat_t e;
            i_clq_valid  = 1'b1;
            i_clq_size   = sz;
            i_clq_vertex = vbase + 16'(b);
            i_clq_strobe = with_strobe && (b == nbeats - 1);
            waited = 0;
            while (1'b1) begin
                @(negedge clk);
                if (o_clq_accept) break;
                waited++;
                if (waited >= 200) begin
                    timed_out = 1'b1;
                    break;
                end
            end
            if (timed_out) begin
                checks_total++;
                $display("FAIL send_timeout beat=%0d accept=0 required=1", b);
                break;
            end
            e.unit   = 5'(unit_exp);
            e.strobe = i_clq_strobe;
            e.size   = sz;
            e.vertex = i_clq_vertex;
            sb_q.push_back(e);
            if (b == 0) begin
                first_wait = waited;
                span       = 1;
            end else begin
                span += waited + 1;
            end
            @(posedge clk);
            #1;
        end
        i_clq_valid  = 1'b0;
        i_clq_strobe = 1'b0;
        if (with_strobe && !timed_out) model_count++;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !o_busy) break;
            n++;
        end
        checks_total++;
        if (n >= 100)
            $display("FAIL %s_drain pending=%0d busy=%0b required pending=0 busy=0", tag, sb_q.size(), o_busy);
        else
            checks_passed++;
        checks_total++;
        if (o_clq_count !== 32'(model_count))
            $display("FAIL %s_count got=%0d required=%0d", tag, o_clq_count, model_count);
        else
            checks_passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        i_reset     = 1'b1;
        i_clq_valid = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        i_reset     = 1'b0;
        model_rr    = 0;
        model_count = 0;
    endtask

    task automatic test_reset();
        i_reset      = 1'b1;
        i_clq_valid  = 1'b1;
        i_clq_size   = 8'h03;
        i_clq_vertex = 16'h0001;
        i_clq_strobe = 1'b0;
        i_unit_ready = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks_total++;
        if (o_clq_accept !== 1'b0) $display("FAIL reset_accept got=%b required=0", o_clq_accept);
        else checks_passed++;
        checks_total++;
        if (o_clq_valid !== '0) $display("FAIL reset_valid got=%b required=0000", o_clq_valid);
        else checks_passed++;
        @(posedge clk);
        #1;
        i_reset     = 1'b0;
        i_clq_valid = 1'b0;
        @(negedge clk);
        checks_total++;
        if (o_clq_count !== 32'd0) $display("FAIL reset_count got=%0d required=0", o_clq_count);
        else checks_passed++;
        checks_total++;
        if (o_busy !== 1'b0) $display("FAIL reset_busy got=%b required=0", o_busy);
        else checks_passed++;
        @(posedge clk);
        #1;
        model_rr    = 0;
        model_count = 0;
    endtask

    task automatic test_round_robin();
        int u, fw, span;
        i_unit_ready = '1;
        sink_mode    = 0;
        for (int c = 0; c < 3; c++) begin
            u = pick_unit(i_unit_ready);
            send_clique(u, 3, 16'(16'h0100 * (c + 1)), 8'h03, 1'b1, fw, span);
            checks_total++;
            if (span !== 3) $display("FAIL rr_span clique=%0d got=%0d required=3", c, span);
            else checks_passed++;
            checks_total++;
            if (fw !== 1) $display("FAIL rr_first_wait clique=%0d got=%0d required=1", c, fw);
            else checks_passed++;
        end
        wait_idle("rr");
    endtask

    task automatic test_rr_skip();
        int u, fw, span;
        apply_reset();
        i_unit_ready = '1;
        for (int c = 0; c < 2; c++) begin
            u = pick_unit(i_unit_ready);
            send_clique(u, 2, 16'(16'h0200 + 16'(c * 16)), 8'h02, 1'b1, fw, span);
        end
        i_unit_ready = 4'b0011;
        u = pick_unit(i_unit_ready);
        send_clique(u, 2, 16'h0300, 8'h02, 1'b1, fw, span);
        i_unit_ready = '1;
        u = pick_unit(i_unit_ready);
        send_clique(u, 2, 16'h0310, 8'h02, 1'b1, fw, span);
        wait_idle("rr_skip");
    endtask

    task automatic test_single();
        int u, fw, span;
        i_unit_ready = '1;
        u = pick_unit(i_unit_ready);
        send_clique(u, 1, 16'h00AB, 8'h01, 1'b1, fw, span);
        @(negedge clk);
        checks_total++;
        if (o_clq_valid[u] !== 1'b1 || o_clq_strobe[u] !== 1'b1 || o_clq_vertex[u*16 +: 16] !== 16'h00AB)
            $display("FAIL single_latency got valid=%b strobe=%b vtx=%h required unit %0d valid strobe vtx=00ab",
                     o_clq_valid, o_clq_strobe, o_clq_vertex[u*16 +: 16], u);
        else
            checks_passed++;
        wait_idle("single");
    endtask

    task automatic test_no_ready();
        int u, fw, span;
        bit bad;
        bad          = 1'b0;
        i_unit_ready = '0;
        i_clq_valid  = 1'b1;
        i_clq_size   = 8'h04;
        i_clq_vertex = 16'h0500;
        i_clq_strobe = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (o_clq_accept !== 1'b0) bad = 1'b1;
        end
        checks_total++;
        if (bad) $display("FAIL no_ready_accept got=1 required=0");
        else checks_passed++;
        @(posedge clk);
        #1;
        i_unit_ready = 4'b0100;
        u = pick_unit(i_unit_ready);
        send_clique(u, 4, 16'h0500, 8'h04, 1'b1, fw, span);
        checks_total++;
        if (fw !== 1) $display("FAIL no_ready_start got=%0d required=1", fw);
        else checks_passed++;
        wait_idle("no_ready");
    endtask

    task automatic test_backpressure();
        int u, fw, span;
        i_unit_ready = '1;
        sink_mode    = 1;
        u = pick_unit(i_unit_ready);
        send_clique(u, 8, 16'h0600, 8'h08, 1'b1, fw, span);
        sink_mode = 0;
        wait_idle("toggle");
        u = pick_unit(i_unit_ready);
        send_clique(u, 8, 16'h0680, 8'h08, 1'b1, fw, span);
        checks_total++;
        if (span !== 8) $display("FAIL stream_span got=%0d required=8", span);
        else checks_passed++;
        wait_idle("stream");
    endtask

    task automatic test_reset_mid();
        int u, fw, span;
        i_unit_ready = '1;
        sink_mode    = 0;
        u = pick_unit(i_unit_ready);
        send_clique(u, 2, 16'h0700, 8'h05, 1'b0, fw, span);
        i_reset     = 1'b1;
        i_clq_valid = 1'b1;
        sb_q.delete();
        @(negedge clk);
        checks_total++;
        if (o_clq_accept !== 1'b0) $display("FAIL midreset_accept got=%b required=0", o_clq_accept);
        else checks_passed++;
        @(posedge clk);
        #1;
        i_reset     = 1'b0;
        i_clq_valid = 1'b0;
        model_rr    = 0;
        model_count = 0;
        @(negedge clk);
        checks_total++;
        if (o_clq_valid !== '0 || o_clq_strobe !== '0 || o_busy !== 1'b0)
            $display("FAIL midreset_outputs got valid=%b strobe=%b busy=%b required all 0",
                     o_clq_valid, o_clq_strobe, o_busy);
        else
            checks_passed++;
        checks_total++;
        if (o_clq_count !== 32'd0) $display("FAIL midreset_count got=%0d required=0", o_clq_count);
        else checks_passed++;
        @(posedge clk);
        #1;
        u = pick_unit(i_unit_ready);
        send_clique(u, 3, 16'h0800, 8'h03, 1'b1, fw, span);
        wait_idle("post_reset");
    endtask

    initial begin
        i_reset      = 1'b1;
        i_clq_valid  = 1'b0;
        i_clq_size   = '0;
        i_clq_vertex = '0;
        i_clq_strobe = 1'b0;
        i_unit_ready = '0;
        test_reset();
        mon_en = 1'b1;
        test_round_robin();
        test_rr_skip();
        test_single();
        test_no_ready();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/clique_dispatch.md
CLIQUE_DISPATCH -- requirements
Module: clique_dispatch

Interface
REQ-001 SHALL have parameter N_UNITS, default `N_UNITS, number of destination units (power of two, 2..32).
REQ-002 SHALL have parameter SIZE_BITS, default `MAX_CLIQUESIZEBITS, clique-size field width.
REQ-003 SHALL have port i_clk300  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port i_reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_clq_valid  in  1  input beat present.
REQ-006 SHALL have port i_clq_size  in  SIZE_BITS  clique size, constant across a clique's beats.
REQ-007 SHALL have port i_clq_vertex  in  16  vertex id of current beat.
REQ-008 SHALL have port i_clq_strobe  in  1  last beat of clique.
REQ-009 SHALL have port o_clq_accept  out  1  input beat consumed this cycle when high with i_clq_valid.
REQ-010 SHALL have port i_unit_ready  in  N_UNITS  unit may be assigned a new clique.
REQ-011 SHALL have ports o_clq_valid, o_clq_strobe  out  N_UNITS  per-unit beat valid / last.
REQ-012 SHALL have ports o_clq_size  out  N_UNITS*SIZE_BITS  and  o_clq_vertex  out  N_UNITS*16, unit i at slice i.
REQ-013 SHALL have port i_clq_accept  in  N_UNITS  per-unit beat consumed.
REQ-014 SHALL have port o_clq_count  out  32  completed cliques dispatched, saturating.
REQ-015 SHALL have port o_busy  out  1  high when not in S_SELECT or output register full.

Function
REQ-016 SHALL implement FSM states S_SELECT, S_STREAM.
REQ-017 In S_SELECT: o_clq_accept SHALL be 0; when i_clq_valid and any i_unit_ready, SHALL latch target = first ready unit at or after rr_ptr (wrapping), go to S_STREAM next cycle.
REQ-018 In S_SELECT with i_clq_valid and no unit ready, SHALL remain in S_SELECT indefinitely.
REQ-019 On selection, rr_ptr SHALL become target+1 modulo N_UNITS.
REQ-020 In S_STREAM, o_clq_accept SHALL equal (!out_full || i_clq_accept[target]); combinational path from i_clq_accept permitted.
REQ-021 Accepted beat SHALL appear in the output register one cycle later (latency 1) on slice target only.
REQ-022 o_clq_valid SHALL be asserted only on bit target, equal to out_full; other bits 0, their data slices don't-care.
REQ-023 Beats of one clique SHALL never be split across units or interleaved with another clique.
REQ-024 Accepted beat with i_clq_strobe=1 SHALL return FSM to S_SELECT next cycle; single-beat cliques allowed.
REQ-025 Output register SHALL drain (hold data until i_clq_accept[target]) even after FSM returns to S_SELECT; new target not latched until out_full=0 or draining that cycle.
REQ-026 Simultaneous accept-in and drain-out SHALL sustain one beat per cycle with no bubble.
REQ-027 o_clq_count SHALL increment when a strobe beat leaves the output register; SHALL saturate at 32'hFFFFFFFF.
REQ-028 i_unit_ready changes during S_STREAM SHALL not affect the current clique.

Reset
REQ-029 On i_reset SHALL set state=S_SELECT, rr_ptr=0, out_full=0, o_clq_count=0; all o_clq_valid=0, o_clq_accept=0.
REQ-030 Reset mid-clique SHALL discard the partial clique; no further beats of it emitted.

Structure
REQ-031 N_UNITS, N_UNITSBITS, MAX_CLIQUESIZEBITS SHALL come from defs.vh; state encodings local.
REQ-032 Output buffer SHALL be one pipe_interlock instance (WIDTH = SIZE_BITS+16+1) with per-unit valid fan-out outside it.

Verification
REQ-033 N=4, all ready, three 3-beat cliques -> units 0,1,2 each receive exact beats; count=3.
REQ-034 rr_ptr=2, ready=4'b0011 -> clique to unit 0; rr_ptr becomes 1.
REQ-035 Single-beat clique (strobe on first beat), vertex 16'h00AB -> unit receives 1 beat, strobe=1, FSM back to S_SELECT.
REQ-036 ready=0 for 20 cycles with input valid -> o_clq_accept=0 throughout; dispatch begins 1 cycle after a ready bit rises.
REQ-037 Target i_clq_accept toggling 1/0 each cycle on 8-beat clique -> no beat lost or duplicated; continuous accept gives 1 beat/cycle.
REQ-038 i_reset asserted at beat 2 of 5 -> next cycle all outputs 0, count 0; following clique starts at unit 0.
